dpram_access_ctrl: RTL
======================

// Module: dpram_access_ctrl
// PURPOSE
// - Clocked initiator front-end for dual_port_ram: turns two independent valid/ready client channels (A, B) into RAM port drives.
// - Registers address, data and write-enable; emits single-cycle write strobes; captures read data.
// - Blocks address hazards between the ports so each client sees a defined ordering.
// - Sits between client logic and the asynchronous dual_port_ram; the RAM itself is unchanged.
// PARAMETERS
// - ADDR_W  4   RAM address width (depth 2**ADDR_W)
// - DATA_W  8   RAM data width
// - CNT_W   16  width of the saturating collision counter
// PORTS
// - clk               in   1       single clock, rising edge
// - rst               in   1       asynchronous reset, active-high
// - req_valid_a/b     in   1       client request valid
// - req_ready_a/b     out  1       request accepted when valid&ready at a clk edge
// - req_we_a/b        in   1       1 = write, 0 = read
// - req_addr_a/b      in   ADDR_W  request address
// - req_wdata_a/b     in   DATA_W  write data
// - rsp_valid_a/b     out  1       one-cycle pulse: read data valid (no backpressure)
// - rsp_rdata_a/b     out  DATA_W  read data, held until the next read response
// - wr_done_a/b       out  1       one-cycle pulse: write strobe completed
// - address_a/b       out  ADDR_W  to RAM
// - data_in_a/b       out  DATA_W  to RAM
// - write_enable_a/b  out  1       to RAM (level; asserted exactly one cycle per write)
// - data_out_a/b      in   DATA_W  from RAM (combinational read)
// - collision_cnt     out  CNT_W   count of hazard stalls, saturating
// BEHAVIOUR
// - Reset: all FSMs enter IDLE; every output is 0 (req_ready, rsp_*, wr_done, address, data_in, write_enable, collision_cnt). Asserting rst mid-operation drops in-flight requests silently (no rsp_valid or wr_done) and drops write_enable immediately.
// - Per-port FSM, states IDLE, WR, RD, CAP:
//   - IDLE: req_ready = ~hazard. On accept, register addr/wdata; go to WR if we, else RD.
//   - WR: write_enable = 1 for this one cycle; wr_done pulses at the end of the cycle; go to IDLE.
//   - RD: drive address with write_enable = 0; go to CAP.
//   - CAP: sample data_out into rsp_rdata; rsp_valid = 1 this cycle; go to IDLE.
// - Latency and throughput:
//   - Read: rsp_valid is asserted 2 cycles after the accept edge.
//   - Write: write_enable is high during the cycle after the accept edge.
//   - Max rate is 1 request per 2 cycles (write) or 3 cycles (read) per port.
// - Hazard means same address AND at least one of the two ops is a write, in either of these cases:
//   - (a) the other port is non-IDLE holding that address (either op may be the write); or
//   - (b) both ports present valid in IDLE in the same cycle and the hazard condition holds there: A wins, B's req_ready = 0.
// - Read-read to the same address is never a hazard; both ports proceed in parallel.
// - collision_cnt increments by 1 for each cycle in which a port holds req_valid=1 in IDLE with req_ready=0 (A+B stalled in the same cycle = +2). It saturates at 2**CNT_W-1 and never wraps.
// - Address/data outputs hold their last value in IDLE; write_enable is 0 outside WR.
// - Request fields are sampled only at the accept edge; later changes are ignored.
// STRUCTURE
// - Package dpram_ctrl_pkg:
//   - typedef enum {IDLE, WR, RD, CAP} port_state_t
//   - localparams for state encoding
// - Sub-module dpram_port_fsm: one port's FSM, registers and RAM drive, with input hazard_block. Instantiated twice.
// - Top-level: hazard compare logic, A-priority tie-break, collision counter.
// TESTING
// - T1: A writes addr 0x2 = 0xAA, then B reads 0x2 -> write_enable_a high 1 cycle; rsp_valid_b 2 cycles after B's accept, rsp_rdata_b = 0xAA.
// - T2: A and B write 0x5 in the same cycle (0x11 / 0x22) -> A accepted, req_ready_b = 0 for 2 cycles, then B accepted; RAM[5] = 0x22; collision_cnt = 2.
// - T3: A writes 0x3 = 0x55 and B writes 0x4 = 0x66 in the same cycle -> both accepted; both write_enables high in the same cycle; collision_cnt = 0.
// - T4: B reads 0x7 (in RD) while A requests a write to 0x7 -> A stalled until B's CAP completes; rsp_rdata_b = old value.
// - T5: assert rst during A's WR -> write_enable_a = 0 immediately, wr_done_a never pulses, all outputs 0.
// - T6: CNT_W=2, force 5 stall cycles -> collision_cnt stops at 3.

Source files
------------

// File: rtl/dpram_ctrl_pkg.sv
// Shared types for the dual-port RAM access controller.
// Holds the per-port state encoding used by the port FSMs and the top-level hazard logic.
package dpram_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_CAP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WR   = ST_WR,
        RD   = ST_RD,
        CAP  = ST_CAP
    } port_state_t;

endpackage

// File: rtl/dpram_port_fsm.sv
// One client port: accepts a valid/ready request, drives the RAM port for one cycle
// (write) or two cycles (read + capture), and reports completion.
module dpram_port_fsm
    import dpram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic              hazard_block_i,
    input  logic [DATA_W-1:0] data_out_i,
    output logic              req_ready_o,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              wr_done_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] data_in_o,
    output logic              write_enable_o,
    output port_state_t       state_o
);

    port_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rsp_valid_q;
    logic              wr_done_q;
    logic              accept;

    assign req_ready_o = (state_q == IDLE) && !hazard_block_i && !rst;
    assign accept      = req_valid_i && req_ready_o;

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = req_we_i ? WR : RD;
            WR:   state_d = IDLE;
            RD:   state_d = CAP;
            CAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_q == RD);
            wr_done_q   <= (state_q == WR);
            if (accept) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if (state_q == RD) rdata_q <= data_out_i;
        end
    end

    // Decoded straight from the state flop so an async reset drops the strobe at once.
    assign write_enable_o = (state_q == WR);
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rdata_q;
    assign wr_done_o      = wr_done_q;
    assign address_o      = addr_q;
    assign data_in_o      = wdata_q;
    assign state_o        = state_q;

endmodule

// File: rtl/dpram_access_ctrl.sv
// Two-client front-end for dual_port_ram: per-port FSMs, same-address hazard
// blocking with port A priority, and a saturating stall counter.
module dpram_access_ctrl
    import dpram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_a,
    input  logic              req_valid_b,
    output logic              req_ready_a,
    output logic              req_ready_b,
    input  logic              req_we_a,
    input  logic              req_we_b,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata_a,
    input  logic [DATA_W-1:0] req_wdata_b,
    output logic              rsp_valid_a,
    output logic              rsp_valid_b,
    output logic [DATA_W-1:0] rsp_rdata_a,
    output logic [DATA_W-1:0] rsp_rdata_b,
    output logic              wr_done_a,
    output logic              wr_done_b,
    output logic [ADDR_W-1:0] address_a,
    output logic [ADDR_W-1:0] address_b,
    output logic [DATA_W-1:0] data_in_a,
    output logic [DATA_W-1:0] data_in_b,
    output logic              write_enable_a,
    output logic              write_enable_b,
    input  logic [DATA_W-1:0] data_out_a,
    input  logic [DATA_W-1:0] data_out_b,
    output logic [CNT_W-1:0]  collision_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    port_state_t      state_a, state_b;
    logic             hazard_a, hazard_b;
    logic             stall_a, stall_b;
    logic [1:0]       stall_inc;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A busy port blocks the other on its held address unless both ops are reads;
    // a same-cycle conflict between two idle requests is resolved in A's favour.
    assign hazard_a = (state_b != IDLE) && (address_b == req_addr_a)
                      && (req_we_a || state_b == WR);
    assign hazard_b = ((state_a != IDLE) && (address_a == req_addr_b)
                       && (req_we_b || state_a == WR))
                   || ((state_a == IDLE) && req_valid_a && req_valid_b
                       && (req_addr_a == req_addr_b) && (req_we_a || req_we_b));

    dpram_port_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_a (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_a),
        .req_we_i       (req_we_a),
        .req_addr_i     (req_addr_a),
        .req_wdata_i    (req_wdata_a),
        .hazard_block_i (hazard_a),
        .data_out_i     (data_out_a),
        .req_ready_o    (req_ready_a),
        .rsp_valid_o    (rsp_valid_a),
        .rsp_rdata_o    (rsp_rdata_a),
        .wr_done_o      (wr_done_a),
        .address_o      (address_a),
        .data_in_o      (data_in_a),
        .write_enable_o (write_enable_a),
        .state_o        (state_a)
    );

    dpram_port_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_b (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_b),
        .req_we_i       (req_we_b),
        .req_addr_i     (req_addr_b),
        .req_wdata_i    (req_wdata_b),
        .hazard_block_i (hazard_b),
        .data_out_i     (data_out_b),
        .req_ready_o    (req_ready_b),
        .rsp_valid_o    (rsp_valid_b),
        .rsp_rdata_o    (rsp_rdata_b),
        .wr_done_o      (wr_done_b),
        .address_o      (address_b),
        .data_in_o      (data_in_b),
        .write_enable_o (write_enable_b),
        .state_o        (state_b)
    );

    assign stall_a   = (state_a == IDLE) && req_valid_a && !req_ready_a;
    assign stall_b   = (state_b == IDLE) && req_valid_b && !req_ready_b;
    assign stall_inc = {1'b0, stall_a} + {1'b0, stall_b};
    assign cnt_sum   = {1'b0, cnt_q} + (CNT_W+1)'(stall_inc);
    assign cnt_d     = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign collision_cnt = cnt_q;

endmodule
